// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding, default
// bit timing and the frame data width. Also holds the parity helper so that
// RX and a future TX side agree on the parity sense.
package uart_pkg;

  // Receiver FSM states. PARITY is only reachable when parity is enabled.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // 100 MHz / 115200 baud, rounded down.
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

  // Data bits per frame (8N1, LSB first).
  localparam int unsigned DATA_BITS = 8;

  // Expected parity bit for a data byte: even parity is the XOR of the data
  // bits, odd parity is its inverse.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/rx_synchronizer.sv
// Two-flop synchronizer for asynchronous level inputs. Resets to all ones so
// an idle-high serial line (or a deasserted active-low handshake) looks idle
// while the design comes out of reset.
module rx_synchronizer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; second stage gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receiver for the USB->serial link: deframes 8N1 (LSB first) characters
// from the raw rx pin and hands complete bytes out over a valid/ready pair.
// Stop-bit and overrun problems are reported as single-cycle pulses.
//
// Build option: define UART_RX_PARITY_EN to insert a parity bit between the
// data bits and the stop bit (sense chosen by PARITY_ODD). Without it the
// receiver is plain 8N1 and parity_err stays low.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,  // must be >= 16
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  // Half a bit from the falling edge lands the start-bit sample mid-bit; every
  // later sample is one full bit after the previous one.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bit_q;
  logic                 frame_err_q;
  logic                 parity_err_q;
  logic [7:0]           data_q;
  logic                 valid_q;
  logic                 overrun_q;

  logic cnt_zero;
  logic stop_sample;
  logic par_bad;
  logic byte_done;

  rx_synchronizer #(
    .WIDTH (1)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Sample-point decode shared by the FSM and the output register.
  always_comb begin
    cnt_zero    = (cnt_q == '0);
    stop_sample = (state_q == STOP) && cnt_zero;
    par_bad     = PARITY_EN && (parity_of(shift_q, PARITY_ODD != 0) != par_bit_q);
    // A good stop bit delivers the byte unless parity already condemned it.
    byte_done   = stop_sample && rx_s && !par_bad;
  end

  // Frame FSM: bit timing, data shifting and the registered error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            cnt_q   <= HALF_LOAD;
            state_q <= START;
          end
        end
        START: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!rx_s) begin
            cnt_q     <= BIT_LOAD;
            bit_idx_q <= '0;
            state_q   <= DATA;
          end else begin
            // Line back high mid start bit: a glitch, not a frame.
            state_q <= IDLE;
          end
        end
        DATA: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            cnt_q   <= BIT_LOAD;
            if (bit_idx_q == LAST_BIT) begin
              state_q <= PARITY_EN ? PARITY : STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            par_bit_q <= rx_s;
            cnt_q     <= BIT_LOAD;
            state_q   <= STOP;
          end
        end
        STOP: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            // Leave at mid stop bit so a back-to-back start edge is not missed.
            // A bad stop bit outranks a parity mismatch.
            frame_err_q  <= !rx_s;
            parity_err_q <= rx_s && par_bad;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output holding register: a byte stays put until consumed; a new byte that
  // finds it still full is dropped and flagged, unless it is being drained now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (byte_done) begin
        if (!valid_q || ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign busy       = (state_q != IDLE);
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign parity_err = PARITY_EN & parity_err_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed self-checking bench for uart_rx_deframer at 16 clocks per bit.
// A passive monitor counts output pulses/valid cycles; the main sequence
// drives frames and compares counter deltas and outputs with hand-computed
// expectations.
module tb_uart_rx_deframer;

  localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned LAT_EXP = 2 + CPB / 2 + 10 * CPB + 1;
`else
  localparam int unsigned LAT_EXP = 2 + CPB / 2 + 9 * CPB + 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int checks   = 0;
  int failures = 0;

  // Monitor state (written only by the monitor processes).
  int unsigned cyc       = 0;
  int unsigned rises     = 0;
  int unsigned valid_cyc = 0;
  int unsigned fe_cnt    = 0;
  int unsigned ov_cnt    = 0;
  int unsigned pe_cnt    = 0;
  int unsigned busy_cyc  = 0;
  int unsigned unstable  = 0;
  int unsigned rise_cyc  = 0;
  logic [7:0]  last_data = 8'h00;
  logic        valid_prev = 1'b0;
  logic [7:0]  data_prev  = 8'h00;

  int unsigned start_cyc;
  int unsigned b_rises, b_vc, b_fe, b_ov, b_pe, b_busy;

  uart_rx_deframer #(
    .CLKS_PER_BIT (CPB),
    .PARITY_ODD   (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    valid_prev <= valid;
    data_prev  <= data;
    if (valid) valid_cyc <= valid_cyc + 1;
    if (valid && !valid_prev) begin
      rises     <= rises + 1;
      last_data <= data;
      rise_cyc  <= cyc;
    end
    if (valid && valid_prev && data != data_prev) unstable <= unstable + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
    if (parity_err) pe_cnt <= pe_cnt + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b_rises = rises;
    b_vc    = valid_cyc;
    b_fe    = fe_cnt;
    b_ov    = ov_cnt;
    b_pe    = pe_cnt;
    b_busy  = busy_cyc;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic has_par, input logic par_bit);
    rx = 1'b0;
    start_cyc = cyc;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(CPB);
    end
    if (has_par) begin
      rx = par_bit;
      wait_cycles(CPB);
    end
    rx = stop_bit;
    wait_cycles(CPB);
    rx = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  localparam logic HAS_PAR = 1'b1;
`else
  localparam logic HAS_PAR = 1'b0;
`endif

  // Correct parity bit for the build, so 8N1 tests also run with parity enabled.
  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

  initial begin
    rx    = 1'b1;
    ready = 1'b0;
    rst_n = 1'b0;
    wait_cycles(3);

    // Reset state
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    rst_n = 1'b1;
    wait_cycles(4);

    // 1: 0x55 with ready held high
    ready = 1'b1;
    snap();
    send_frame(8'h55, 1'b1, HAS_PAR, even_par(8'h55));
    wait_cycles(8);
    check("t1_rises", rises - b_rises, 1);
    check("t1_data", 32'(last_data), 32'h55);
    check("t1_valid_cycles", valid_cyc - b_vc, 1);
    check("t1_frame_err", fe_cnt - b_fe, 0);
    check("t1_overrun", ov_cnt - b_ov, 0);
    check("t1_parity_err", pe_cnt - b_pe, 0);
    check("t1_latency_ok", 32'((rise_cyc - start_cyc >= LAT_EXP - 1) &&
                               (rise_cyc - start_cyc <= LAT_EXP + 1)), 1);

    // 2: 0xA3 then 0x0F back-to-back while ready is low
    ready = 1'b0;
    snap();
    send_frame(8'hA3, 1'b1, HAS_PAR, even_par(8'hA3));
    send_frame(8'h0F, 1'b1, HAS_PAR, even_par(8'h0F));
    wait_cycles(8);
    check("t2_data_held", 32'(data), 32'hA3);
    check("t2_valid_held", 32'(valid), 32'h1);
    check("t2_overrun", ov_cnt - b_ov, 1);
    check("t2_data_stable", unstable, 0);
    ready = 1'b1;
    wait_cycles(1);
    check("t2_valid_drop", 32'(valid), 32'h0);
    wait_cycles(40);
    check("t2_rises", rises - b_rises, 1);
    check("t2_no_second", 32'(valid), 32'h0);

    // 3: 0xFF with a low stop bit, then a good 0x12
    snap();
    send_frame(8'hFF, 1'b0, HAS_PAR, even_par(8'hFF));
    rx = 1'b1;
    wait_cycles(40);
    check("t3_frame_err", fe_cnt - b_fe, 1);
    check("t3_no_valid", rises - b_rises, 0);
    check("t3_no_parity_err", pe_cnt - b_pe, 0);
    snap();
    send_frame(8'h12, 1'b1, HAS_PAR, even_par(8'h12));
    wait_cycles(8);
    check("t3_rises", rises - b_rises, 1);
    check("t3_data", 32'(last_data), 32'h12);
    check("t3_no_frame_err", fe_cnt - b_fe, 0);

    // 4: quarter-bit low glitch on an idle line
    snap();
    rx = 1'b0;
    wait_cycles(CPB / 4);
    rx = 1'b1;
    wait_cycles(30);
    check("t4_busy_cycles", busy_cyc - b_busy, 8);
    check("t4_no_valid", rises - b_rises, 0);
    check("t4_no_errors", (fe_cnt - b_fe) + (ov_cnt - b_ov) + (pe_cnt - b_pe), 0);
    check("t4_idle", 32'(busy), 32'h0);

    // 5: reset during the 4th data bit of 0x81, then 0x3C
    rx = 1'b0;
    wait_cycles(CPB);
    rx = 1'b1;  // bit0
    wait_cycles(CPB);
    rx = 1'b0;  // bit1
    wait_cycles(CPB);
    rx = 1'b0;  // bit2
    wait_cycles(CPB);
    rx = 1'b0;  // bit3
    wait_cycles(CPB / 2);
    check("t5_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_data", 32'(data), 32'h00);
    check("t5_rst_valid", 32'(valid), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_pulses", 32'({frame_err, overrun, parity_err}), 32'h0);
    rx = 1'b1;
    wait_cycles(4);
    rst_n = 1'b1;
    wait_cycles(40);
    check("t5_no_partial", rises - b_rises, 0);
    snap();
    send_frame(8'h3C, 1'b1, HAS_PAR, even_par(8'h3C));
    wait_cycles(8);
    check("t5_rises", rises - b_rises, 1);
    check("t5_data", 32'(last_data), 32'h3C);
    check("t5_data_out", 32'(data), 32'h3C);
    check("t5_no_frame_err", fe_cnt - b_fe, 0);

`ifdef UART_RX_PARITY_EN
    // 6: even parity, 0x07 needs parity bit 1
    snap();
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    wait_cycles(8);
    check("t6_parity_err", pe_cnt - b_pe, 1);
    check("t6_no_valid", rises - b_rises, 0);
    snap();
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    wait_cycles(8);
    check("t6_rises", rises - b_rises, 1);
    check("t6_data", 32'(last_data), 32'h07);
    check("t6_no_parity_err", pe_cnt - b_pe, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- UART receiver for the USB->serial link. Takes the raw `usb_rx` pin and delivers received bytes to the top-level logic over a valid/ready handshake.
- Replaces the pin-level echo path with byte-level data, so top-level logic (LEDs, command decoder, TX path) consumes whole bytes.
- Format is 8N1, LSB first, fixed baud derived from the 100 MHz clock.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit (100 MHz / 115200); must be >= 16.
- PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined: 0 = even, 1 = odd.

Ports:
- clk  input  1  100 MHz system clock
- rst_n  input  1  asynchronous active-low reset
- rx  input  1  raw serial line (`usb_rx`), idle high, asynchronous to clk
- data  output  8  received byte
- valid  output  1  data holds an undelivered byte
- ready  input  1  consumer accepts byte when valid && ready at a clk edge
- busy  output  1  frame reception in progress (state != IDLE)
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: byte completed while previous still held
- parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 without macro)

Behaviour:
- Reset:
  - One clock, `clk`. Reset is asynchronous and active-low on `rst_n`, with no other reset source.
  - All outputs reset to 0.
  - Synchronizer flops and the internal rx shadow reset to 1 (idle line).
  - State resets to IDLE; counters reset to 0.
- Input synchronisation: `rx` passes through a 2-flop synchronizer. All decisions use the synchronized value `rx_s`.
- States: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: on `rx_s` == 0, load the bit counter with CLKS_PER_BIT/2 - 1 and go to START.
  - START: count down to 0, then re-sample. If `rx_s` == 0, load CLKS_PER_BIT - 1 and go to DATA. If `rx_s` == 1, treat it as a glitch and return to IDLE with no error.
  - DATA: at each counter expiry, shift `rx_s` into bit 7 of the shift register (shift right, LSB first) and reload the counter. After 8 bits, go to STOP (or PARITY when enabled).
  - STOP: at counter expiry, sample `rx_s`.
    - If 1: byte complete.
    - If 0: pulse `frame_err` and drop the byte.
    - Either way, return to IDLE on the next cycle. No wait for the end of the stop bit, so back-to-back frames are accepted.
- Bit counter width: $clog2(CLKS_PER_BIT). The counter is a down-counter and never wraps. It is reloaded explicitly in every state that uses it.
- Output register:
  - On byte complete with `valid` == 0: `data` <= shift register and `valid` <= 1 on the next edge.
  - `valid` falls on the edge where `valid && ready`. `data` is stable while `valid` is 1.
  - Byte complete while `valid` && !`ready`: pulse `overrun`; the new byte is discarded and the old byte is retained.
  - Byte complete in the same cycle as `valid && ready`: load the new byte, keep `valid` = 1, no overrun.
- Latency: `valid` rises 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clocks after the falling edge on `rx`, ±1 clock.
- Error pulses are exactly 1 clock wide and mutually exclusive per frame.
- Reset mid-frame: immediate return to IDLE; a partial byte is never delivered.
- `rx` stuck low: after a frame_err, IDLE re-enters START immediately. This repeats one frame_err per frame time and is acceptable.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - Parity bit is sampled mid-bit and checked against the XOR of the data bits, inverted when PARITY_ODD = 1.
  - On mismatch: `parity_err` pulses at the STOP sample and the byte is dropped, even if the stop bit is good. If the stop bit is also bad, `frame_err` takes precedence.
- Undefined: 8N1 only; `parity_err` is tied to 0.

Decomposition:
- Package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - DEFAULT_CLKS_PER_BIT = 868
  - DATA_BITS = 8
- Sub-module `rx_synchronizer`: 2-flop, reset value 1, parameterised width. Reused later by the TX-side CTS input.

Test Plan:
1. 0x55 sent at CLKS_PER_BIT = 16, `ready` held 1 -> `data` = 0x55, `valid` high exactly 1 cycle, no error pulses.
2. 0xA3 then 0x0F back-to-back, `ready` = 0 until after the second frame -> `data` stays 0xA3, `overrun` pulses once. After `ready`, `valid` drops and 0x0F is never seen.
3. Frame 0xFF with the stop bit driven low -> `frame_err` pulses 1 cycle, `valid` stays 0. A following good 0x12 is received correctly.
4. Low glitch of CLKS_PER_BIT/4 clocks on idle line -> returns to IDLE. No `valid`, no errors, `busy` high only during the glitch check.
5. `rst_n` asserted during the 4th data bit of 0x81 -> all outputs 0 immediately. After release, 0x3C is received with correct data.
6. (UART_RX_PARITY_EN, PARITY_ODD = 0) 0x07 with parity bit 0 -> `parity_err` pulses, no `valid`. 0x07 with parity bit 1 -> `data` = 0x07 valid.
